// File: rtl/cpu_fetch_unit.sv
// Instruction fetch stage: reads a two-byte instruction (hi at pc, lo at pc+1)
// from the shared byte-wide sync RAM and hands it to execute via valid/ready.
module cpu_fetch_unit #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mem_grant,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_cs,
  output logic                    mem_we,
  output logic                    mem_oe,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic [2*DATA_WIDTH-1:0] ir,
  output logic [ADDR_WIDTH-1:0]   ir_pc,
  output logic                    ir_valid,
  input  logic                    ir_ready,
  input  logic                    redirect_valid,
  input  logic [ADDR_WIDTH-1:0]   redirect_pc,
  output logic [ADDR_WIDTH-1:0]   pc
);

  typedef enum logic [2:0] {REQ_HI, CAP_HI, REQ_LO, CAP_LO, HOLD} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] hi;

  assign mem_we   = 1'b0;
  assign mem_oe   = mem_cs;
  assign mem_addr = (state == REQ_LO) ? pc + ADDR_WIDTH'(1) : pc;

  // A redirect suppresses the request: the address it would use is stale.
  always_comb begin
    state_nxt = state;
    mem_cs    = 1'b0;
    if (redirect_valid) begin
      state_nxt = REQ_HI;
    end else begin
      case (state)
        REQ_HI: begin
          mem_cs = mem_grant;
          if (mem_grant) state_nxt = CAP_HI;
        end
        CAP_HI: state_nxt = REQ_LO;
        REQ_LO: begin
          mem_cs = mem_grant;
          if (mem_grant) state_nxt = CAP_LO;
        end
        CAP_LO: state_nxt = HOLD;
        HOLD:   if (ir_valid && ir_ready) state_nxt = REQ_HI;
        default: state_nxt = REQ_HI;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= REQ_HI;
      pc       <= RESET_PC;
      hi       <= '0;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      if (redirect_valid) begin
        pc       <= redirect_pc;
        hi       <= '0;
        ir_valid <= 1'b0;
      end else begin
        case (state)
          CAP_HI: hi <= mem_rdata;
          CAP_LO: begin
            ir       <= {hi, mem_rdata};
            ir_pc    <= pc;
            pc       <= pc + ADDR_WIDTH'(2);
            ir_valid <= 1'b1;
          end
          HOLD:   if (ir_valid && ir_ready) ir_valid <= 1'b0;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Bench for cpu_fetch_unit: behavioural sync RAM, scoreboard of expected
// {ir, ir_pc} popped on each handshake, plus per-scenario timing checks.
module tb_cpu_fetch_unit;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst_n, mem_grant, mem_cs, mem_we, mem_oe;
  logic          ir_valid, ir_ready, redirect_valid;
  logic [AW-1:0] mem_addr, ir_pc, redirect_pc, pc;
  logic [DW-1:0] mem_rdata;
  logic [2*DW-1:0] ir;
  logic [DW-1:0] ram [256];

  typedef struct packed {
    logic [2*DW-1:0] ir;
    logic [AW-1:0]   pc;
  } exp_t;

  exp_t sb_q[$];
  int   hs_q[$];
  exp_t mon_e;
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;
  int   r0;

  cpu_fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .mem_grant(mem_grant), .mem_addr(mem_addr),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe), .mem_rdata(mem_rdata),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid), .ir_ready(ir_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .pc(pc)
  );

  always #5 clk = ~clk;

  // Unrequested cycles return junk so a mistimed capture shows up.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_cs && mem_oe && !mem_we) mem_rdata <= ram[mem_addr];
    else mem_rdata <= 8'($urandom);
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1 && ir_valid === 1'b1 && ir_ready === 1'b1) begin
      hs_q.push_back(cyc);
      total++;
      if (sb_q.size() == 0) begin
        $display("FAIL sb_unexpected: got ir=%h ir_pc=%h, wanted no instruction", ir, ir_pc);
      end else begin
        mon_e = sb_q.pop_front();
        if ({ir, ir_pc} !== mon_e) $display("FAIL sb_instr: got ir=%h ir_pc=%h, wanted ir=%h ir_pc=%h",
                                            ir, ir_pc, mon_e.ir, mon_e.pc);
        else passed++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    rst_n = 1'b0; mem_grant = 1'b1; ir_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);
    sb_q.delete();
    hs_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++;
    if ({ir, ir_pc, ir_valid, pc, mem_we} !== 34'h0)
      $display("FAIL reset_vals: got ir=%h ir_pc=%h v=%b pc=%h we=%b, wanted all 0",
               ir, ir_pc, ir_valid, pc, mem_we);
    else passed++;
  endtask

  task automatic test_first_fetch();
    logic [1:0] exp_cv [5] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b01};
    logic [7:0] exp_a  [5] = '{8'h00, 8'h00, 8'h01, 8'h00, 8'h00};
    do_reset();
    ram[0] = 8'h10; ram[1] = 8'h0C;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      total++;
      if ({mem_cs, ir_valid} !== exp_cv[k] || (mem_cs && mem_addr !== exp_a[k]))
        $display("FAIL first_seq[%0d]: got cs=%b v=%b addr=%h, wanted cs=%b v=%b addr=%h",
                 k, mem_cs, ir_valid, mem_addr, exp_cv[k][1], exp_cv[k][0], exp_a[k]);
      else passed++;
    end
    for (int k = 0; k < 10; k++) begin
      total++;
      if ({ir, ir_pc, ir_valid, pc, mem_we} !== {16'h100C, 8'h00, 1'b1, 8'h02, 1'b0})
        $display("FAIL first_hold[%0d]: got ir=%h ir_pc=%h v=%b pc=%h we=%b, wanted 100c 00 1 02 0",
                 k, ir, ir_pc, ir_valid, pc, mem_we);
      else passed++;
      @(negedge clk); #1;
    end
  endtask

  task automatic test_stream();
    logic [7:0] prog [8] = '{8'h10, 8'h0C, 8'h20, 8'h0E, 8'h10, 8'h0D, 8'h30, 8'h0B};
    do_reset();
    for (int i = 0; i < 8; i++) ram[i] = prog[i];
    sb_q.push_back('{16'h100C, 8'h00});
    sb_q.push_back('{16'h200E, 8'h02});
    sb_q.push_back('{16'h100D, 8'h04});
    sb_q.push_back('{16'h300B, 8'h06});
    ir_ready = 1'b1; rst_n = 1'b1; r0 = cyc;
    for (int i = 0; i < 40 && hs_q.size() < 4; i++) begin @(negedge clk); #1; end
    ir_ready = 1'b0;
    total++;
    if (hs_q.size() != 4) $display("FAIL stream_count: got %0d handshakes, wanted 4", hs_q.size());
    else begin
      passed++;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (hs_q[i] != r0 + 4 + 5 * i)
          $display("FAIL stream_timing[%0d]: got cycle %0d, wanted %0d", i, hs_q[i] - r0, 4 + 5 * i);
        else passed++;
      end
    end
  endtask

  task automatic test_grant_stall();
    do_reset();
    ir_ready = 1'b1; rst_n = 1'b1; r0 = cyc;
    sb_q.push_back('{16'h100C, 8'h00});
    sb_q.push_back('{16'h200E, 8'h02});
    repeat (7) @(negedge clk);
    #1;
    total++;
    if ({mem_cs, mem_addr} !== {1'b1, 8'h03})
      $display("FAIL stall_pre: got cs=%b addr=%h, wanted cs=1 addr=03", mem_cs, mem_addr);
    else passed++;
    mem_grant = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      else #1;
      total++;
      if (mem_cs !== 1'b0) $display("FAIL stall_cs[%0d]: got cs=%b, wanted 0", k, mem_cs);
      else passed++;
    end
    @(negedge clk);
    mem_grant = 1'b1;
    #1;
    total++;
    if ({mem_cs, mem_addr} !== {1'b1, 8'h03})
      $display("FAIL stall_resume: got cs=%b addr=%h, wanted cs=1 addr=03", mem_cs, mem_addr);
    else passed++;
    for (int i = 0; i < 30 && hs_q.size() < 2; i++) begin @(negedge clk); #1; end
    ir_ready = 1'b0;
    total++;
    if (hs_q.size() != 2 || hs_q[0] != r0 + 4 || hs_q[1] != r0 + 12)
      $display("FAIL stall_timing: got %0d handshakes, second at cycle %0d, wanted 2 with second at 12",
               hs_q.size(), (hs_q.size() > 1) ? hs_q[1] - r0 : -1);
    else passed++;
  endtask

  task automatic test_redirect_cap_hi();
    do_reset();
    ram[0] = 8'h10; ram[1] = 8'h0C; ram[8'h1E] = 8'hF0; ram[8'h1F] = 8'hFF;
    sb_q.push_back('{16'hF0FF, 8'h1E});
    ir_ready = 1'b1; rst_n = 1'b1; r0 = cyc;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 8'h1E;
    #1;
    total++;
    if (mem_cs !== 1'b0) $display("FAIL redir_cs: got cs=%b, wanted 0", mem_cs);
    else passed++;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    total++;
    if ({pc, ir_valid} !== {8'h1E, 1'b0})
      $display("FAIL redir_pc: got pc=%h v=%b, wanted pc=1e v=0", pc, ir_valid);
    else passed++;
    for (int i = 0; i < 20 && hs_q.size() < 1; i++) begin @(negedge clk); #1; end
    total++;
    if (hs_q.size() != 1 || hs_q[0] != r0 + 6 || pc !== 8'h20)
      $display("FAIL redir_timing: got %0d handshakes pc=%h, wanted 1 at cycle 6 pc=20", hs_q.size(), pc);
    else passed++;
    ir_ready = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    ram[8'hFF] = 8'h84; ram[0] = 8'h00;
    sb_q.push_back('{16'h8400, 8'hFF});
    ir_ready = 1'b1; rst_n = 1'b1; r0 = cyc;
    redirect_valid = 1'b1; redirect_pc = 8'hFF;
    #1;
    total++;
    if (mem_cs !== 1'b0) $display("FAIL wrap_redir_cs: got cs=%b, wanted 0", mem_cs);
    else passed++;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({mem_cs, mem_addr} !== {1'b1, 8'h00})
      $display("FAIL wrap_lo_addr: got cs=%b addr=%h, wanted cs=1 addr=00", mem_cs, mem_addr);
    else passed++;
    for (int i = 0; i < 20 && hs_q.size() < 1; i++) begin @(negedge clk); #1; end
    total++;
    if (hs_q.size() != 1 || hs_q[0] != r0 + 5 || pc !== 8'h01)
      $display("FAIL wrap_pc: got %0d handshakes pc=%h, wanted 1 at cycle 5 pc=01", hs_q.size(), pc);
    else passed++;
    ir_ready = 1'b0;
  endtask

  task automatic test_reset_hold();
    do_reset();
    ram[0] = 8'h10; ram[1] = 8'h0C;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    total++;
    if (ir_valid !== 1'b1) $display("FAIL rh_pre: got v=%b, wanted 1", ir_valid);
    else passed++;
    rst_n = 1'b0; ir_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h55;
    @(negedge clk);
    #1;
    total++;
    if ({ir, ir_pc, ir_valid, pc} !== 33'h0)
      $display("FAIL rh_vals: got ir=%h ir_pc=%h v=%b pc=%h, wanted all 0", ir, ir_pc, ir_valid, pc);
    else passed++;
    rst_n = 1'b1; redirect_valid = 1'b0; ir_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); #1;
      total++;
      if (ir_valid !== (k == 4) || (k == 4 && ir !== 16'h100C))
        $display("FAIL rh_refetch[%0d]: got v=%b ir=%h, wanted v=%b ir=100c", k, ir_valid, ir, k == 4);
      else passed++;
    end
  endtask

  initial begin
    rst_n = 1'b0; mem_grant = 1'b0; ir_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    test_reset();
    test_first_fetch();
    test_stream();
    test_grant_stall();
    test_redirect_cap_hi();
    test_wrap();
    test_reset_hold();
    total++;
    if (sb_q.size() != 0) $display("FAIL sb_leftover: got %0d pending, wanted 0", sb_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cpu_fetch_unit.md
Name: cpu_fetch_unit

Overview:
- Instruction fetch stage of the 8-bit accumulator CPU; sits directly upstream of decode/execute.
- Reads each two-byte instruction from the byte-wide synchronous RAM (single_port_sync_ram_large):
  - high byte at PC: opcode in [15:12], modifier in [11:10]
  - low byte at PC+1: operand address
- Presents the assembled 16-bit word to execute over a valid/ready handshake.
- Shares the RAM port with execute via a grant input and accepts PC redirects from execute (jump, skip, halt).

Parameters:
- ADDR_WIDTH, 8, RAM address and PC width
- DATA_WIDTH, 8, RAM data width; instruction word is 2*DATA_WIDTH
- RESET_PC, 8'h00, PC value loaded on reset

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous active-low reset
- mem_grant  input  1  fetch may drive the RAM this cycle
- mem_addr  output  ADDR_WIDTH  RAM address
- mem_cs  output  1  RAM chip select
- mem_we  output  1  RAM write enable; constant 0
- mem_oe  output  1  RAM output enable
- mem_rdata  input  DATA_WIDTH  RAM read data, valid the cycle after a granted request
- ir  output  2*DATA_WIDTH  assembled instruction {hi, lo}
- ir_pc  output  ADDR_WIDTH  address of ir's high byte
- ir_valid  output  1  ir holds an unconsumed instruction
- ir_ready  input  1  execute accepts ir
- redirect_valid  input  1  load PC from redirect_pc
- redirect_pc  input  ADDR_WIDTH  new fetch address
- pc  output  ADDR_WIDTH  current fetch PC

Behaviour:
- Single clock domain. Reset is synchronous, active-low: sampled on rising clk only.
- Reset values:
  - state=REQ_HI, pc=RESET_PC
  - ir=0, ir_pc=0, ir_valid=0
  - hi-byte holding register=0
- States: REQ_HI, CAP_HI, REQ_LO, CAP_LO, HOLD.
- REQ_HI:
  - mem_addr=pc; mem_cs=mem_oe=mem_grant (combinational)
  - mem_grant=1 -> CAP_HI; else stay in REQ_HI (retry)
- CAP_HI:
  - No request (mem_cs=mem_oe=0).
  - Latch mem_rdata into hi register -> REQ_LO.
- REQ_LO:
  - mem_addr=pc+1, modulo 2^ADDR_WIDTH (0xFF+1=0x00); mem_cs=mem_oe=mem_grant
  - granted -> CAP_LO; else stay in REQ_LO (hi byte retained)
- CAP_LO:
  - ir<={hi, mem_rdata}; ir_pc<=pc; pc<=pc+2 (mod 2^ADDR_WIDTH); ir_valid<=1 -> HOLD.
- HOLD:
  - No request; ir, ir_pc, ir_valid held stable.
  - ir_valid&&ir_ready -> ir_valid<=0 -> REQ_HI.
- mem_addr=pc in CAP_HI, CAP_LO and HOLD; RAM ignores it since cs=0.
- Latency:
  - first rising edge with rst_n=1 and grant held high leaves REQ_HI
  - ir_valid rises after the 4th such edge
  - steady-state throughput: 1 instruction per 5 cycles with ir_ready=1
- Redirect (any state, highest priority below reset):
  - pc<=redirect_pc; ir_valid<=0; partial hi byte discarded; state<=REQ_HI
  - no RAM request is issued in the redirect cycle (mem_cs=0 when redirect_valid=1)
- redirect_valid with ir_valid&&ir_ready in the same cycle: instruction counts as consumed; redirect applies.
- Reset mid-operation: all state returns to reset values on that edge regardless of grant, ready or redirect; any in-flight RAM data is ignored.
- mem_grant is ignored outside REQ_HI/REQ_LO.
- mem_we is never 1; execute owns all RAM writes.

Test Plan:
- RAM[0]=0x10, RAM[1]=0x0C, grant=1, ready=0, release reset -> after edge 4: ir=0x100C, ir_pc=0x00, ir_valid=1, pc=0x02; held stable 10 cycles.
- Preload bytes 0x10 0C 20 0E 10 0D 30 0B, ready=1 -> ir sequence 0x100C, 0x200E, 0x100D, 0x300B with ir_pc 0,2,4,6; one valid cycle per 5 clocks.
- Grant low for 3 cycles during REQ_LO of the instruction at 0x02 -> mem_cs=0 those cycles; ir still 0x200E; hi byte preserved; ir_valid delayed exactly 3 cycles.
- RAM[0x1E]=0xF0, RAM[0x1F]=0xFF; redirect_valid with redirect_pc=0x1E asserted in CAP_HI -> ir_valid stays 0, next ir=0xF0FF, ir_pc=0x1E.
- redirect_pc=0xFF, RAM[0xFF]=0x84, RAM[0x00]=0x00 -> ir=0x8400, ir_pc=0xFF, pc wraps to 0x01.
- rst_n low for one edge while in HOLD with ir_valid=1 -> ir_valid=0, ir=0, pc=RESET_PC, state REQ_HI on that edge.
